// File: rtl/wav_voice_scheduler.sv
// ============================================================================
// Module   : wav_voice_scheduler
// Purpose  : Multi-voice one-shot sample playback sharing one sound-ROM port.
//            Optional build macro VOICE_LOOP_EN adds a per-voice loop input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wav_voice_scheduler #(
  parameter int VOICES   = 4,
  parameter int ADDR_W   = 16,
  parameter int PRESCALE = 2177,
  parameter int MIX_W    = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [VOICES-1:0]        trig,
  input  logic [VOICES-1:0]        stop,
`ifdef VOICE_LOOP_EN
  input  logic [VOICES-1:0]        loop,
`endif
  input  logic [VOICES*ADDR_W-1:0] start_addr,
  input  logic [VOICES*ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0]        rom_a,
  output logic                     rom_rd,
  input  logic [7:0]               rom_d,
  output logic [VOICES-1:0]        busy,
  output logic [VOICES*8-1:0]      voice_sample,
  output logic [MIX_W-1:0]         mix_out,
  output logic                     mix_valid
);

  localparam int c_VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int c_PW = $clog2(PRESCALE + 1);
  localparam logic [c_VW-1:0] c_LAST_V   = c_VW'(VOICES - 1);
  localparam logic [c_PW-1:0] c_PRESCALE = c_PW'(PRESCALE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_MIX   = 3'd4
  } state_t;

  state_t                   r_state;
  logic [c_PW-1:0]          r_presc;
  logic [c_VW-1:0]          r_vidx;
  logic [ADDR_W-1:0]        r_addr [VOICES];
  logic [VOICES-1:0]        r_busy;
  logic [VOICES-1:0][7:0]   r_sample;
  logic [ADDR_W-1:0]        r_rom_a;
  logic                     r_rom_rd;
  logic [MIX_W-1:0]         r_mix_out;
  logic                     r_mix_valid;

  logic                     w_tick;
  logic                     w_last;
  logic                     w_cur_busy;
  logic                     w_cur_loop;
  logic [ADDR_W-1:0]        w_cur_addr;
  logic [ADDR_W-1:0]        w_cur_end;
  logic [MIX_W-1:0]         w_mix;

  assign w_tick     = (r_presc == c_PRESCALE);
  assign w_last     = (r_vidx == c_LAST_V);
  assign w_cur_busy = r_busy[r_vidx];
  assign w_cur_addr = r_addr[r_vidx];
  assign w_cur_end  = end_addr[int'(r_vidx)*ADDR_W +: ADDR_W];

`ifdef VOICE_LOOP_EN
  logic [ADDR_W-1:0] w_cur_start;
  assign w_cur_start = start_addr[int'(r_vidx)*ADDR_W +: ADDR_W];
  assign w_cur_loop  = loop[r_vidx];
`else
  assign w_cur_loop  = 1'b0;
`endif

  // Only voices still busy after their capture contribute to the mix.
  always_comb begin
    w_mix = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (r_busy[i]) w_mix = w_mix + MIX_W'(r_sample[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_presc <= '0;
    else          r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_vidx      <= '0;
      r_busy      <= '0;
      r_sample    <= {VOICES{8'h80}};
      r_rom_a     <= '0;
      r_rom_rd    <= 1'b0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      for (int i = 0; i < VOICES; i++) r_addr[i] <= '0;
    end else begin
      r_rom_rd    <= 1'b0;
      r_mix_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_vidx  <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_cur_busy) begin
            r_rom_a  <= w_cur_addr;
            r_rom_rd <= 1'b1;
            r_state  <= ST_WAIT;
          end else if (w_last) begin
            r_state <= ST_MIX;
          end else begin
            r_vidx <= r_vidx + 1'b1;
          end
        end
        ST_WAIT: r_state <= ST_CAPT;
        ST_CAPT: begin
          r_sample[r_vidx] <= rom_d;
          if (w_cur_addr == w_cur_end) begin
`ifdef VOICE_LOOP_EN
            if (w_cur_loop) r_addr[r_vidx] <= w_cur_start;
            else            r_busy[r_vidx] <= 1'b0;
`else
            if (!w_cur_loop) r_busy[r_vidx] <= 1'b0;
`endif
          end else begin
            r_addr[r_vidx] <= w_cur_addr + 1'b1;
          end
          if (w_last) r_state <= ST_MIX;
          else begin
            r_vidx  <= r_vidx + 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_MIX: begin
          r_mix_out   <= w_mix;
          r_mix_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Later assignments override the capture update of busy/addr.
      for (int i = 0; i < VOICES; i++) begin
        if (trig[i]) begin
          r_busy[i] <= 1'b1;
          r_addr[i] <= start_addr[i*ADDR_W +: ADDR_W];
        end else if (stop[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign rom_a        = r_rom_a;
  assign rom_rd       = r_rom_rd;
  assign busy         = r_busy;
  assign voice_sample = r_sample;
  assign mix_out      = r_mix_out;
  assign mix_valid    = r_mix_valid;

`ifndef SYNTHESIS
  a_tick_in_idle: assert property (@(posedge clk) disable iff (!reset_n)
    w_tick |-> (r_state == ST_IDLE));
`endif

endmodule

`default_nettype wire

// File: tb/tb_wav_voice_scheduler.sv
// ============================================================================
// Module   : tb_wav_voice_scheduler
// Purpose  : Table-driven, scoreboard-based bench for wav_voice_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wav_voice_scheduler;

  localparam int VOICES   = 4;
  localparam int ADDR_W   = 16;
  localparam int PRESCALE = 19;
  localparam int MIX_W    = 11;
  localparam int BUDGET   = 3 * (PRESCALE + 1);

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [VOICES-1:0]        trig = '0;
  logic [VOICES-1:0]        stop = '0;
  logic [VOICES*ADDR_W-1:0] start_addr;
  logic [VOICES*ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0]        rom_a;
  logic                     rom_rd;
  logic [7:0]               rom_d = 8'h00;
  logic [VOICES-1:0]        busy;
  logic [VOICES*8-1:0]      voice_sample;
  logic [MIX_W-1:0]         mix_out;
  logic                     mix_valid;
`ifdef VOICE_LOOP_EN
  logic [VOICES-1:0]        loop = '0;
`endif

  bit rom_mode = 1'b0;  // 0: byte = address[7:0], 1: byte = 0xFF
  int checks   = 0;
  int failures = 0;

  logic [15:0] rd_q  [$];
  logic [10:0] mix_q [$];

  typedef struct packed {
    logic [3:0]       trig;
    logic [3:0]       stop;
    logic [3:0]       ct;    // trig pulse aimed at the CAPT of the first read
    logic [3:0]       cs;    // stop pulse aimed at the CAPT of the first read
    bit               mode;
    int               n_rd;
    logic [3:0][15:0] rd;
    logic [10:0]      mix;
    logic [3:0]       busy;
  } vec_t;

  vec_t tbl [24];

  wav_voice_scheduler #(
    .VOICES(VOICES), .ADDR_W(ADDR_W), .PRESCALE(PRESCALE), .MIX_W(MIX_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trig(trig), .stop(stop),
`ifdef VOICE_LOOP_EN
    .loop(loop),
`endif
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_a(rom_a), .rom_rd(rom_rd), .rom_d(rom_d), .busy(busy),
    .voice_sample(voice_sample), .mix_out(mix_out), .mix_valid(mix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd) rom_d <= rom_mode ? 8'hFF : rom_a[7:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rom_a"}, 64'(rom_a), 64'h0);
    chk({tag, " rom_rd"}, 64'(rom_rd), 64'h0);
    chk({tag, " busy"}, 64'(busy), 64'h0);
    chk({tag, " voice_sample"}, 64'(voice_sample), 64'h8080_8080);
    chk({tag, " mix_out"}, 64'(mix_out), 64'h0);
    chk({tag, " mix_valid"}, 64'(mix_valid), 64'h0);
  endtask

  function automatic vec_t mk(input logic [3:0] t, input logic [3:0] s,
                              input logic [3:0] ct, input logic [3:0] cs,
                              input bit m, input int n,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [10:0] mx, input logic [3:0] b);
    vec_t v;
    v.trig = t;  v.stop = s;  v.ct = ct;  v.cs = cs;
    v.mode = m;  v.n_rd = n;
    v.rd[0] = a0; v.rd[1] = a1; v.rd[2] = a2; v.rd[3] = a3;
    v.mix = mx;  v.busy = b;
    return v;
  endfunction

  // Drive one row's pulses from IDLE, then follow the DUT through one tick.
  task automatic run_row(input int idx, input vec_t r);
    bit got;
    bit inject;
    int nrd;
    int last_cyc;
    got = 1'b0; inject = 1'b0; nrd = 0; last_cyc = 0;
    rom_mode = r.mode;
    for (int k = 0; k < r.n_rd; k++) rd_q.push_back(r.rd[k]);
    mix_q.push_back(r.mix);
    trig = r.trig;
    stop = r.stop;
    for (int cyc = 0; cyc < BUDGET && !got; cyc++) begin
      @(negedge clk);
      trig = '0;
      stop = '0;
      if (inject) begin
        trig   = r.ct;
        stop   = r.cs;
        inject = 1'b0;
      end
      if (rom_rd) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL row%0d unexpected rom_rd: got addr %0h expected none", idx, rom_a);
        end else begin
          chk($sformatf("row%0d rom_a", idx), 64'(rom_a), 64'(rd_q.pop_front()));
        end
        if (r.n_rd == 4 && nrd > 0)
          chk($sformatf("row%0d rom_rd spacing", idx), 64'(cyc - last_cyc), 64'd3);
        if (nrd == 0 && (r.ct | r.cs) != 4'b0) inject = 1'b1;
        last_cyc = cyc;
        nrd++;
      end
      if (mix_valid) begin
        got = 1'b1;
        chk($sformatf("row%0d mix_out", idx), 64'(mix_out), 64'(mix_q.pop_front()));
        chk($sformatf("row%0d busy", idx), 64'(busy), 64'(r.busy));
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL row%0d mix_valid timeout: got none expected 1 within %0d clks", idx, BUDGET);
      mix_q.delete();
    end
    if (rd_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL row%0d missing rom reads: got %0d expected %0d", idx, nrd, r.n_rd);
      rd_q.delete();
    end
  endtask

  initial begin
    bit seen;
    // voice 3..0
    start_addr = {16'h0200, 16'hFFFF, 16'h0100, 16'h0010};
    end_addr   = {16'h0203, 16'h0000, 16'h0107, 16'h0012};

    //            trig     stop     ct       cs      mode n  rd0      rd1      rd2      rd3      mix      busy
    tbl[0]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0,    16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[1]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0010, 16'h0,   16'h0,   16'h0,   11'h010, 4'b0001);
    tbl[2]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0011, 16'h0,   16'h0,   16'h0,   11'h011, 4'b0001);
    tbl[3]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0012, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0,    16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[5]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'hFFFF, 16'h0,   16'h0,   16'h0,   11'h0FF, 4'b0100);
    tbl[6]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0000, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[7]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0,    16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[8]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 4, 16'h0010, 16'h0100, 16'hFFFF, 16'h0200, 11'h3FC, 4'b1111);
    tbl[9]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4, 16'h0011, 16'h0101, 16'h0000, 16'h0201, 11'h2FD, 4'b1011);
    tbl[10] = mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 2, 16'h0012, 16'h0202, 16'h0,   16'h0,   11'h0FF, 4'b1000);
    tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0203, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[12] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0100, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0010);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0101, 16'h0,   16'h0,   16'h0,   11'h001, 4'b0010);
    tbl[14] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 1, 16'h0100, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0010);
    tbl[15] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0101, 16'h0,   16'h0,   16'h0,   11'h001, 4'b0010);
    tbl[16] = mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0, 16'h0,    16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[17] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0100, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0010);
    tbl[18] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 1, 16'h0101, 16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);
    tbl[19] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0010, 16'h0,   16'h0,   16'h0,   11'h010, 4'b0001);
    tbl[20] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0011, 16'h0,   16'h0,   16'h0,   11'h011, 4'b0001);
    tbl[21] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1, 16'h0012, 16'h0,   16'h0,   16'h0,   11'h012, 4'b0001);
    tbl[22] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0010, 16'h0,   16'h0,   16'h0,   11'h010, 4'b0001);
    tbl[23] = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 16'h0,    16'h0,   16'h0,   16'h0,   11'h000, 4'b0000);

    // Power-on reset.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset_n = 1'b1;
    run_row(100, tbl[0]);

    // Reset in the middle of a scan, then no reads without a new trigger.
    trig = 4'b0010;
    @(negedge clk);
    trig = '0;
    seen = 1'b0;
    for (int c = 0; c < BUDGET && !seen; c++) begin
      @(negedge clk);
      if (rom_rd) seen = 1'b1;
    end
    chk("midscan rom_rd seen", 64'(seen), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset("midscan");
    repeat (4) @(negedge clk);
    chk_reset("midscan held");
    reset_n = 1'b1;
    run_row(101, tbl[0]);
    run_row(102, tbl[0]);

    for (int i = 0; i < 24; i++) run_row(i, tbl[i]);
    chk("final voice_sample", 64'(voice_sample), 64'h03FF_0110);

`ifdef VOICE_LOOP_EN
    start_addr[63:48] = 16'h0005;
    end_addr[63:48]   = 16'h0006;
    loop = 4'b1000;
    run_row(200, mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0005, 16'h0, 16'h0, 16'h0, 11'h005, 4'b1000));
    run_row(201, mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0006, 16'h0, 16'h0, 16'h0, 11'h006, 4'b1000));
    run_row(202, mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h0005, 16'h0, 16'h0, 16'h0, 11'h005, 4'b1000));
    run_row(203, mk(4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 16'h0,    16'h0, 16'h0, 16'h0, 11'h000, 4'b0000));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
